// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// memory geometry and the load range check.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  localparam int IMEM_DEPTH_WORDS = 8192;
  localparam int BYTES_PER_WORD   = 4;
  localparam int BIDX_W           = $clog2(BYTES_PER_WORD);

  // True when the load is word-aligned and its last word still fits in the
  // memory. Operands are 33 bits wide so the end-of-load sum cannot wrap.
  function automatic logic load_fits(input logic [31:0] base,
                                     input logic [32:0] count,
                                     input logic [32:0] depth);
    logic [32:0] end_word;
    end_word = {3'b000, base[31:2]} + count;
    return (base[1:0] == 2'b00) && (end_word <= depth);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four stream bytes into one big-endian 32-bit word.
// The word output already includes the byte being accepted this cycle, so
// the loader can capture a completed word on the same edge as the last byte.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BIDX_W-1:0] idx;
  logic [31:0]       sr;

  // Earlier bytes shift toward the MSB, giving big-endian packing.
  assign word      = accept ? {sr[23:0], byte_in} : sr;
  assign word_full = accept && (idx == BIDX_W'(BYTES_PER_WORD - 1));

  // Byte index and shift register; the index wraps to 0 after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      sr  <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + BIDX_W'(1);
      sr  <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes from a boot/debug source into the instruction memory write
// port, holding the CPU in reset for the duration of the load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int CNT_W       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      addr;
  logic [CNT_W-1:0] remaining;

  logic             accept;
  logic             word_full;
  logic [31:0]      word;
  logic             start_take;
  logic             fits;
  logic             pk_clear;

  logic             mem_we_d;
  logic [31:0]      mem_addr_d;
  logic [31:0]      mem_wdata_d;
  logic             busy_d;
  logic             done_d;
  logic             error_d;

  assign byte_ready = (state == ST_COLLECT);
  assign accept     = byte_valid && byte_ready;
  assign start_take = (state == ST_IDLE) && start;
  assign fits       = load_fits(base_addr, 33'(word_count), 33'(DEPTH_WORDS));
  assign pk_clear   = start_take && fits && (word_count != '0);

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .clear     (pk_clear),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a rejected start leaves the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && fits) begin
          state_nxt = (word_count == '0) ? ST_FINISH : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (word_full) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_nxt = (remaining == CNT_W'(1)) ? ST_FINISH : ST_COLLECT;
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write address and remaining-word counter for the load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (pk_clear) begin
      addr      <= base_addr;
      remaining <= word_count;
    end else if (state == ST_WRITE) begin
      addr      <= addr + 32'd4;
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Next values of the registered outputs, so each one is valid in the
  // same cycle as the state it belongs to.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = (state_nxt != ST_IDLE);
    error_d     = error;
    if ((state == ST_COLLECT) && word_full) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr;
      mem_wdata_d = word;
    end
    if (start_take) begin
      error_d = !fits;
    end
    done_d = (state_nxt == ST_FINISH) || (start_take && !fits);
  end

  // Output registers; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      cpu_hold  <= busy_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule
